// File: rtl/load_store_buffer_pkg.sv
// Shared CPU definitions for the load/store buffer: opcodes, funct3 codes, memory size
// encoding, FSM states and the operand wakeup helper.
package load_store_buffer_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'd0,
        MEM_SIZE_HALF = 2'd1,
        MEM_SIZE_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM   = 2'd1,
        DRAIN = 2'd2
    } lsb_state_e;

    typedef struct packed {
        logic [4:0]  dep;
        logic [31:0] val;
    } operand_t;

    // A pending tag is satisfied by the common CDB first, then by our own result bus.
    function automatic operand_t resolve_operand(
        input operand_t    op,
        input logic        cdb_rdy,
        input logic [4:0]  cdb_rob,
        input logic [31:0] cdb_val,
        input logic        ls_rdy,
        input logic [4:0]  ls_rob,
        input logic [31:0] ls_val
    );
        operand_t res;
        res = op;
        if (op.dep != 5'd0) begin
            if (cdb_rdy && (op.dep == cdb_rob)) begin
                res.dep = 5'd0;
                res.val = cdb_val;
            end else if (ls_rdy && (op.dep == ls_rob)) begin
                res.dep = 5'd0;
                res.val = ls_val;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational load data formatter: selects and sign/zero-extends the returned memory word.
module load_extender
    import load_store_buffer_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_value
);

    always_comb begin
        o_value = i_rdata;
        case (i_funct3)
            F3_LB:   o_value = {{24{i_rdata[7]}}, i_rdata[7:0]};
            F3_LH:   o_value = {{16{i_rdata[15]}}, i_rdata[15:0]};
            F3_LW:   o_value = i_rdata;
            F3_LBU:  o_value = {24'd0, i_rdata[7:0]};
            F3_LHU:  o_value = {16'd0, i_rdata[15:0]};
            default: o_value = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue: captures operands from the CDBs, issues the head entry to
// memory once ready and broadcasts its result.
module load_store_buffer
    import load_store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _lsb_issue,
    input  logic        _lsb_is_store,
    input  logic [2:0]  _lsb_funct3,
    input  logic [4:0]  _lsb_rob_id,
    input  logic [4:0]  _lsb_dep_1,
    input  logic [4:0]  _lsb_dep_2,
    input  logic [31:0] _lsb_value_1,
    input  logic [31:0] _lsb_value_2,
    input  logic [31:0] _lsb_imm,
    output logic        _lsb_full,
    input  logic        _cdb_ready,
    input  logic [4:0]  _cdb_rob_id,
    input  logic [31:0] _cdb_value,
    input  logic        _store_ready,
    output logic        _mem_req,
    output logic        _mem_we,
    output logic [31:0] _mem_addr,
    output logic [31:0] _mem_wdata,
    output logic [1:0]  _mem_size,
    input  logic        _mem_done,
    input  logic [31:0] _mem_rdata,
    output logic        _cdb_ls_ready,
    output logic [4:0]  _cdb_ls_rob_id,
    output logic [31:0] _cdb_ls_value
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic             r_valid    [DEPTH];
    logic             r_is_store [DEPTH];
    logic [2:0]       r_funct3   [DEPTH];
    logic [4:0]       r_rob_id   [DEPTH];
    logic [31:0]      r_imm      [DEPTH];
    operand_t         r_op1      [DEPTH];
    operand_t         r_op2      [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    lsb_state_e r_state;
    logic       r_flushed;
    logic       r_cur_store;
    logic [2:0] r_cur_funct3;
    logic [4:0] r_cur_rob;

    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [1:0]  r_mem_size;
    logic        r_ls_ready;
    logic [4:0]  r_ls_rob;
    logic [31:0] r_ls_value;

    operand_t    w_op1 [DEPTH];
    operand_t    w_op2 [DEPTH];
    operand_t    w_new1;
    operand_t    w_new2;
    logic        w_head_ready;
    logic        w_start;
    logic        w_pop;
    logic        w_push;
    logic [31:0] w_ext_value;

    load_extender u_load_extender (
        .i_funct3 (r_cur_funct3),
        .i_rdata  (_mem_rdata),
        .o_value  (w_ext_value)
    );

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_op1[i] = resolve_operand(r_op1[i], _cdb_ready, _cdb_rob_id, _cdb_value,
                                       r_ls_ready, r_ls_rob, r_ls_value);
            w_op2[i] = resolve_operand(r_op2[i], _cdb_ready, _cdb_rob_id, _cdb_value,
                                       r_ls_ready, r_ls_rob, r_ls_value);
        end
        w_new1 = resolve_operand('{dep: _lsb_dep_1, val: _lsb_value_1}, _cdb_ready,
                                 _cdb_rob_id, _cdb_value, r_ls_ready, r_ls_rob, r_ls_value);
        w_new2 = resolve_operand('{dep: _lsb_dep_2, val: _lsb_value_2}, _cdb_ready,
                                 _cdb_rob_id, _cdb_value, r_ls_ready, r_ls_rob, r_ls_value);
    end

    // Loads never wait on the store-data tag.
    assign w_head_ready = r_valid[r_head] && (r_op1[r_head].dep == 5'd0) &&
                          (!r_is_store[r_head] || (r_op2[r_head].dep == 5'd0));
    assign w_start = (r_state == IDLE) && !_clear && w_head_ready &&
                     (!r_is_store[r_head] || _store_ready);
    assign w_pop   = (r_state == MEM) && _mem_done && !r_flushed && !_clear;
    assign w_push  = _lsb_issue && !_clear && ((r_count != FULL_CNT) || w_pop);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]   <= 1'b0;
                r_op1[i].dep <= 5'd0;
                r_op2[i].dep <= 5'd0;
            end
        end else if (rdy_in) begin
            if (_clear) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_valid[i] <= 1'b0;
                end
                r_head  <= r_tail;
                r_count <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_valid[i]) begin
                        r_op1[i] <= w_op1[i];
                        r_op2[i] <= w_op2[i];
                    end
                end
                if (w_pop) begin
                    r_valid[r_head] <= 1'b0;
                    r_head          <= r_head + PTR_W'(1);
                end
                // Written after the pop so a full-queue push into the freed slot wins.
                if (w_push) begin
                    r_valid[r_tail]    <= 1'b1;
                    r_is_store[r_tail] <= _lsb_is_store;
                    r_funct3[r_tail]   <= _lsb_funct3;
                    r_rob_id[r_tail]   <= _lsb_rob_id;
                    r_imm[r_tail]      <= _lsb_imm;
                    r_op1[r_tail]      <= w_new1;
                    r_op2[r_tail]      <= w_new2;
                    r_tail             <= r_tail + PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= IDLE;
            r_flushed    <= 1'b0;
            r_cur_store  <= 1'b0;
            r_cur_funct3 <= 3'd0;
            r_cur_rob    <= 5'd0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_mem_size   <= 2'd0;
            r_ls_ready   <= 1'b0;
            r_ls_rob     <= 5'd0;
            r_ls_value   <= 32'd0;
        end else if (rdy_in) begin
            r_mem_req  <= 1'b0;
            r_ls_ready <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= r_is_store[r_head];
                        r_mem_addr   <= r_op1[r_head].val + r_imm[r_head];
                        r_mem_wdata  <= r_is_store[r_head] ? r_op2[r_head].val : 32'd0;
                        r_mem_size   <= r_funct3[r_head][1:0];
                        r_cur_store  <= r_is_store[r_head];
                        r_cur_funct3 <= r_funct3[r_head];
                        r_cur_rob    <= r_rob_id[r_head];
                        r_flushed    <= 1'b0;
                        r_state      <= MEM;
                    end
                end
                MEM: begin
                    if (_mem_done) begin
                        r_state <= IDLE;
                        if (!_clear && !r_flushed) begin
                            r_ls_ready <= 1'b1;
                            r_ls_rob   <= r_cur_rob;
                            r_ls_value <= r_cur_store ? 32'd0 : w_ext_value;
                        end
                    end else if (_clear) begin
                        // A committed store must still reach memory; its result is moot.
                        if (r_cur_store) begin
                            r_flushed <= 1'b1;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (_mem_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign _lsb_full     = (r_count == FULL_CNT);
    assign _mem_req      = r_mem_req;
    assign _mem_we       = r_mem_we;
    assign _mem_addr     = r_mem_addr;
    assign _mem_wdata    = r_mem_wdata;
    assign _mem_size     = r_mem_size;
    assign _cdb_ls_ready = r_ls_ready;
    assign _cdb_ls_rob_id = r_ls_rob;
    assign _cdb_ls_value = r_ls_value;

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed bench for load_store_buffer with immediate-assertion checks.
module tb_load_store_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _lsb_issue;
    logic        _lsb_is_store;
    logic [2:0]  _lsb_funct3;
    logic [4:0]  _lsb_rob_id;
    logic [4:0]  _lsb_dep_1;
    logic [4:0]  _lsb_dep_2;
    logic [31:0] _lsb_value_1;
    logic [31:0] _lsb_value_2;
    logic [31:0] _lsb_imm;
    logic        _lsb_full;
    logic        _cdb_ready;
    logic [4:0]  _cdb_rob_id;
    logic [31:0] _cdb_value;
    logic        _store_ready;
    logic        _mem_req;
    logic        _mem_we;
    logic [31:0] _mem_addr;
    logic [31:0] _mem_wdata;
    logic [1:0]  _mem_size;
    logic        _mem_done;
    logic [31:0] _mem_rdata;
    logic        _cdb_ls_ready;
    logic [4:0]  _cdb_ls_rob_id;
    logic [31:0] _cdb_ls_value;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    load_store_buffer #(.DEPTH(8)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        ._clear        (_clear),
        ._lsb_issue    (_lsb_issue),
        ._lsb_is_store (_lsb_is_store),
        ._lsb_funct3   (_lsb_funct3),
        ._lsb_rob_id   (_lsb_rob_id),
        ._lsb_dep_1    (_lsb_dep_1),
        ._lsb_dep_2    (_lsb_dep_2),
        ._lsb_value_1  (_lsb_value_1),
        ._lsb_value_2  (_lsb_value_2),
        ._lsb_imm      (_lsb_imm),
        ._lsb_full     (_lsb_full),
        ._cdb_ready    (_cdb_ready),
        ._cdb_rob_id   (_cdb_rob_id),
        ._cdb_value    (_cdb_value),
        ._store_ready  (_store_ready),
        ._mem_req      (_mem_req),
        ._mem_we       (_mem_we),
        ._mem_addr     (_mem_addr),
        ._mem_wdata    (_mem_wdata),
        ._mem_size     (_mem_size),
        ._mem_done     (_mem_done),
        ._mem_rdata    (_mem_rdata),
        ._cdb_ls_ready (_cdb_ls_ready),
        ._cdb_ls_rob_id(_cdb_ls_rob_id),
        ._cdb_ls_value (_cdb_ls_value)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_issue(input logic st, input logic [2:0] f3, input logic [4:0] rob,
                             input logic [4:0] d1, input logic [4:0] d2,
                             input logic [31:0] v1, input logic [31:0] v2,
                             input logic [31:0] imm);
        _lsb_issue    = 1'b1;
        _lsb_is_store = st;
        _lsb_funct3   = f3;
        _lsb_rob_id   = rob;
        _lsb_dep_1    = d1;
        _lsb_dep_2    = d2;
        _lsb_value_1  = v1;
        _lsb_value_2  = v2;
        _lsb_imm      = imm;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [4:0] rob,
                         input logic [4:0] d1, input logic [4:0] d2,
                         input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] imm);
        set_issue(st, f3, rob, d1, d2, v1, v2, imm);
        step();
        _lsb_issue = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!_mem_req && n < 20) begin
            step();
            n++;
        end
        check({tag, " req"}, 32'(_mem_req), 32'd1);
    endtask

    // Wait for a request, check it, answer it and check the broadcast that follows.
    task automatic serve(input string tag, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [1:0] size,
                         input logic [31:0] rdata, input logic [4:0] rob,
                         input logic [31:0] value);
        wait_req(tag);
        check({tag, " addr"}, _mem_addr, addr);
        check({tag, " we"}, 32'(_mem_we), 32'(we));
        check({tag, " size"}, 32'(_mem_size), 32'(size));
        if (we) check({tag, " wdata"}, _mem_wdata, wdata);
        step();
        check({tag, " req pulse"}, 32'(_mem_req), 32'd0);
        check({tag, " addr held"}, _mem_addr, addr);
        _mem_done  = 1'b1;
        _mem_rdata = rdata;
        step();
        _mem_done = 1'b0;
        check({tag, " ls ready"}, 32'(_cdb_ls_ready), 32'd1);
        check({tag, " ls rob"}, 32'(_cdb_ls_rob_id), 32'(rob));
        check({tag, " ls value"}, _cdb_ls_value, value);
        check({tag, " no req on done"}, 32'(_mem_req), 32'd0);
        step();
        check({tag, " ls pulse"}, 32'(_cdb_ls_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; _clear = 1'b0; _lsb_issue = 1'b0;
        _lsb_is_store = 1'b0; _lsb_funct3 = 3'd0; _lsb_rob_id = 5'd0;
        _lsb_dep_1 = 5'd0; _lsb_dep_2 = 5'd0; _lsb_value_1 = 32'd0;
        _lsb_value_2 = 32'd0; _lsb_imm = 32'd0; _cdb_ready = 1'b0;
        _cdb_rob_id = 5'd0; _cdb_value = 32'd0; _store_ready = 1'b0;
        _mem_done = 1'b0; _mem_rdata = 32'd0;
        step();
        step();
        rst_in = 1'b0;
        check("rst req", 32'(_mem_req), 32'd0);
        check("rst full", 32'(_lsb_full), 32'd0);
        check("rst ls ready", 32'(_cdb_ls_ready), 32'd0);
        check("rst addr", _mem_addr, 32'd0);

        // lb with sign extension
        issue(1'b0, 3'b000, 5'd1, 5'd0, 5'd0, 32'h1000, 32'd0, 32'd3);
        serve("lb", 32'h1003, 1'b0, 32'd0, 2'd0, 32'h0000_0080, 5'd1, 32'hFFFF_FF80);

        // lw waits on base tag 5
        issue(1'b0, 3'b010, 5'd2, 5'd5, 5'd0, 32'd0, 32'd0, 32'h10);
        check("lw dep wait0", 32'(_mem_req), 32'd0);
        step();
        check("lw dep wait1", 32'(_mem_req), 32'd0);
        _cdb_ready = 1'b1; _cdb_rob_id = 5'd5; _cdb_value = 32'h200;
        step();
        _cdb_ready = 1'b0;
        check("lw wake no req", 32'(_mem_req), 32'd0);
        serve("lw", 32'h210, 1'b0, 32'd0, 2'd2, 32'h1234_5678, 5'd2, 32'h1234_5678);

        // lh with base forwarded from the CDB in the issue cycle
        set_issue(1'b0, 3'b001, 5'd3, 5'd6, 5'd0, 32'd0, 32'd0, 32'd2);
        _cdb_ready = 1'b1; _cdb_rob_id = 5'd6; _cdb_value = 32'h400;
        step();
        _lsb_issue = 1'b0; _cdb_ready = 1'b0;
        serve("lh fwd", 32'h402, 1'b0, 32'd0, 2'd1, 32'h0000_8001, 5'd3, 32'hFFFF_8001);

        // lhu then lbu back to back; lbu imm -1 wraps the sum
        issue(1'b0, 3'b101, 5'd4, 5'd0, 5'd0, 32'h10, 32'd0, 32'h6);
        issue(1'b0, 3'b100, 5'd5, 5'd0, 5'd0, 32'h20, 32'd0, 32'hFFFF_FFFF);
        serve("lhu", 32'h16, 1'b0, 32'd0, 2'd1, 32'hFFFF_8001, 5'd4, 32'h0000_8001);
        serve("lbu", 32'h1F, 1'b0, 32'd0, 2'd0, 32'h1234_56FF, 5'd5, 32'h0000_00FF);

        // second load woken by the buffer's own result
        issue(1'b0, 3'b010, 5'd10, 5'd0, 5'd0, 32'h40, 32'd0, 32'd0);
        issue(1'b0, 3'b010, 5'd11, 5'd10, 5'd0, 32'd0, 32'd0, 32'd4);
        serve("self A", 32'h40, 1'b0, 32'd0, 2'd2, 32'h500, 5'd10, 32'h500);
        serve("self B", 32'h504, 1'b0, 32'd0, 2'd2, 32'h1, 5'd11, 32'h1);

        // sw held until the ROB head is the store
        _store_ready = 1'b0;
        issue(1'b1, 3'b010, 5'd7, 5'd0, 5'd0, 32'h100, 32'hDEAD_BEEF, 32'h20);
        for (int i = 0; i < 10; i++) begin
            check("sw held", 32'(_mem_req), 32'd0);
            step();
        end
        _store_ready = 1'b1;
        serve("sw", 32'h120, 1'b1, 32'hDEAD_BEEF, 2'd2, 32'hFFFF_FFFF, 5'd7, 32'd0);
        _store_ready = 1'b0;

        // fill the queue; head executes while the rest wait on tag 9
        issue(1'b0, 3'b010, 5'd1, 5'd0, 5'd0, 32'h1000, 32'd0, 32'd0);
        for (int i = 1; i < 8; i++) begin
            check("not full", 32'(_lsb_full), 32'd0);
            issue(1'b0, 3'b010, 5'(20 + i), 5'd9, 5'd0, 32'd0, 32'd0, 32'(4 * i));
        end
        check("full", 32'(_lsb_full), 32'd1);
        check("full head addr", _mem_addr, 32'h1000);
        issue(1'b0, 3'b010, 5'd31, 5'd0, 5'd0, 32'h5000, 32'd0, 32'd0);
        check("full ignore", 32'(_lsb_full), 32'd1);
        set_issue(1'b0, 3'b010, 5'd30, 5'd0, 5'd0, 32'h3000, 32'd0, 32'd8);
        _mem_done = 1'b1; _mem_rdata = 32'h11;
        step();
        _lsb_issue = 1'b0; _mem_done = 1'b0;
        check("push+pop full", 32'(_lsb_full), 32'd1);
        check("push+pop ls rob", 32'(_cdb_ls_rob_id), 32'd1);
        check("push+pop ls value", _cdb_ls_value, 32'h11);
        _cdb_ready = 1'b1; _cdb_rob_id = 5'd9; _cdb_value = 32'h2000;
        step();
        _cdb_ready = 1'b0;
        for (int i = 1; i < 8; i++) begin
            serve("fill", 32'h2000 + 32'(4 * i), 1'b0, 32'd0, 2'd2, 32'(i), 5'(20 + i), 32'(i));
        end
        serve("wrap", 32'h3008, 1'b0, 32'd0, 2'd2, 32'hA5A5_0000, 5'd30, 32'hA5A5_0000);
        check("drained", 32'(_lsb_full), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ignored issue absent", 32'(_mem_req), 32'd0);
        end

        // flush a load in flight; coincident issue is dropped
        issue(1'b0, 3'b010, 5'd12, 5'd0, 5'd0, 32'h600, 32'd0, 32'd0);
        wait_req("clr ld");
        _clear = 1'b1;
        set_issue(1'b0, 3'b010, 5'd13, 5'd0, 5'd0, 32'h700, 32'd0, 32'd0);
        step();
        _clear = 1'b0; _lsb_issue = 1'b0;
        check("clr full", 32'(_lsb_full), 32'd0);
        _mem_done = 1'b1; _mem_rdata = 32'h55;
        step();
        _mem_done = 1'b0;
        check("clr no bcast", 32'(_cdb_ls_ready), 32'd0);
        step();
        check("clr no bcast2", 32'(_cdb_ls_ready), 32'd0);
        check("clr dropped issue", 32'(_mem_req), 32'd0);
        issue(1'b0, 3'b000, 5'd15, 5'd0, 5'd0, 32'h800, 32'd0, 32'd1);
        serve("post clr", 32'h801, 1'b0, 32'd0, 2'd0, 32'h7F, 5'd15, 32'h7F);

        // reset while a store is in MEM
        _store_ready = 1'b1;
        issue(1'b1, 3'b010, 5'd14, 5'd0, 5'd0, 32'h900, 32'hCAFE_F00D, 32'd0);
        wait_req("rst st");
        _store_ready = 1'b0;
        check("rst st we", 32'(_mem_we), 32'd1);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        check("mid rst req", 32'(_mem_req), 32'd0);
        check("mid rst we", 32'(_mem_we), 32'd0);
        check("mid rst addr", _mem_addr, 32'd0);
        check("mid rst wdata", _mem_wdata, 32'd0);
        check("mid rst size", 32'(_mem_size), 32'd0);
        check("mid rst ls rob", 32'(_cdb_ls_rob_id), 32'd0);
        check("mid rst ls value", _cdb_ls_value, 32'd0);
        check("mid rst full", 32'(_lsb_full), 32'd0);
        _mem_done = 1'b1; _mem_rdata = 32'h99;
        step();
        _mem_done = 1'b0;
        check("late done ls", 32'(_cdb_ls_ready), 32'd0);
        step();
        check("late done ls2", 32'(_cdb_ls_ready), 32'd0);
        check("late done req", 32'(_mem_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_buffer.md
LOAD_STORE_BUFFER -- requirements
Module: load_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of queue entries (power of two).
REQ-002 SHALL have ports clk_in (in, 1, system clock) and rst_in (in, 1, synchronous active-high reset), listed first.
REQ-003 SHALL have port rdy_in (in, 1), which holds all state when low.
REQ-004 SHALL have port _clear (in, 1), the ROB mispredict flush.
REQ-005 SHALL have issue ports: _lsb_issue (in, 1), _lsb_is_store (in, 1), _lsb_funct3 (in, 3), _lsb_rob_id (in, 5), _lsb_dep_1 / _lsb_dep_2 (in, 5, ROB tag of base/store-data, 0 = ready), _lsb_value_1 / _lsb_value_2 (in, 32), _lsb_imm (in, 32).
REQ-006 SHALL output _lsb_full (out, 1), high when count == DEPTH.
REQ-007 SHALL have wakeup ports _cdb_ready (in, 1), _cdb_rob_id (in, 5), _cdb_value (in, 32).
REQ-008 SHALL have port _store_ready (in, 1), high when the ROB head is a store.
REQ-009 SHALL have memory ports _mem_req (out, 1), _mem_we (out, 1), _mem_addr (out, 32), _mem_wdata (out, 32), _mem_size (out, 2; 0=byte, 1=half, 2=word), _mem_done (in, 1), _mem_rdata (in, 32).
REQ-010 SHALL have result ports _cdb_ls_ready (out, 1), _cdb_ls_rob_id (out, 5), _cdb_ls_value (out, 32).

Function
REQ-011 SHALL be a circular FIFO; _lsb_issue writes the entry at tail; the entry at head executes; strictly in order.
REQ-012 SHALL compare a set dep tag against _cdb_rob_id and against its own _cdb_ls_rob_id each cycle; on match, it SHALL capture the value and clear the tag to 0.
REQ-013 SHALL forward a result arriving in the same cycle as _lsb_issue into the newly written entry.
REQ-014 SHALL treat the head as ready when both tags are 0; store-data tag SHALL be ignored for loads.
REQ-015 SHALL compute address as value_1 + imm, modulo 2^32.
REQ-016 SHALL use FSM states IDLE, MEM, DRAIN.
REQ-017 SHALL, in IDLE, raise _mem_req for one cycle and enter MEM when the head is ready and (it is a load, or _store_ready is high).
REQ-018 SHALL hold _mem_addr, _mem_we, _mem_wdata and _mem_size stable while in MEM.
REQ-019 SHALL, in MEM on _mem_done, pop head, pulse _cdb_ls_ready for one cycle in the next cycle, and return to IDLE; a new request SHALL NOT be raised in that same cycle.
REQ-020 SHALL produce the load value per funct3: 000 sign-extend byte, 001 sign-extend half, 010 word, 100 zero-extend byte, 101 zero-extend half.
REQ-021 SHALL produce a store result with value 0; for stores, _mem_wdata SHALL be value_2 and _mem_size SHALL be funct3[1:0].
REQ-022 SHALL handle _clear as follows: empty the queue (head = tail, count = 0); MEM with a load goes to DRAIN; MEM with a store continues; IDLE stays IDLE.
REQ-023 SHALL, in DRAIN, discard the result on _mem_done, not broadcast, and go to IDLE.
REQ-024 SHALL accept _lsb_issue while full and DEPTH entries are held only if a pop occurs in the same cycle; otherwise the issue is ignored (the issuer obeys _lsb_full).
REQ-025 SHALL apply simultaneous push and pop with count unchanged, and SHALL wrap pointers from DEPTH-1 to 0.
REQ-026 SHALL drop a _lsb_issue that coincides with _clear.

Reset
REQ-027 SHALL, on rst_in, clear: head, tail, count = 0; state IDLE; all tags and valid bits 0; _mem_req, _mem_we, _cdb_ls_ready 0; _mem_addr, _mem_wdata, _cdb_ls_rob_id, _cdb_ls_value 0; _mem_size 0.
REQ-028 SHALL give rst_in priority over _clear and rdy_in.

Structure
REQ-029 SHALL place opcode/funct3 constants, the mem_size encoding and the FSM state encoding in the shared CPU package.
REQ-030 SHALL implement load extension in one combinational sub-module, load_extender.

Verification
REQ-031 SHALL cover: issue lb, base 0x1000 ready, imm 3; _mem_rdata 0x00000080 -> _mem_addr 0x1003, _mem_size 0, broadcast value 0xFFFFFF80.
REQ-032 SHALL cover: issue lw with dep_1 = 5; _cdb_ready with rob 5, value 0x200, two cycles later -> no _mem_req before wakeup; afterwards _mem_addr 0x200+imm.
REQ-033 SHALL cover: issue sw (rob 7, data 0xDEADBEEF) with _store_ready low for 10 cycles -> no request; raise it -> _mem_we 1, wdata 0xDEADBEEF, then _cdb_ls_rob_id 7, value 0.
REQ-034 SHALL cover: load in MEM, pulse _clear, then _mem_done -> no broadcast, _lsb_full 0, count 0, next issue executes normally.
REQ-035 SHALL cover: fill DEPTH entries -> _lsb_full 1; pop while issuing -> full stays 1 and the tail wraps to entry 0 correctly.
REQ-036 SHALL cover: rst_in asserted during MEM -> all outputs 0 next cycle and a late _mem_done is ignored.
